// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I pipeline hazard controller.
//   fwd_sel_t       : EX-stage operand forwarding select encoding
//   hz_state_t      : sequencing FSM states (RUN / MEM_WAIT)
//   RESULT_SRC_LOAD : ResultSrcE encoding that marks a load in Execute
//   sat_inc8        : saturating 8-bit increment used by the wait watchdog
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Increment that sticks at 255 so a very long wait never wraps back to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Purely combinational forwarding select for one EX-stage source operand.
// Ports:
//   rs_e        in  source register of the operand in Execute
//   rd_m, rd_w  in  destinations in Memory / Writeback
//   reg_write_m in  Memory-stage write enable
//   reg_write_w in  Writeback-stage write enable
//   fwd_sel     out FWD_MEM / FWD_WB / FWD_RF
// Memory has priority over Writeback since it holds the younger result;
// x0 is hard-wired zero and never forwarded.
// -----------------------------------------------------------------------------
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_m,
    input  logic                      reg_write_w,
    output fwd_sel_t                  fwd_sel
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

    // Priority select: Memory result, then Writeback result, else register file.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Hazard and sequencing controller for a 5-stage RV32I pipeline.
//   - EX operand forwarding selects (two forward_unit instances)
//   - load-use stall (one bubble), taken branch/jump flush
//   - whole-pipeline freeze while a data-memory access is outstanding
//   - memory-wait watchdog with sticky MemTimeout
// Optional build macro: HAZARD_PERF_CNT_EN adds StallCnt / FlushCnt /
// MemWaitCnt cycle counters (CNT_WIDTH bits, wrapping).
// Ports:
//   clk, rst (async, active-high)
//   Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE       : Decode/Execute info
//   RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM     : Memory/Writeback info
//   ForwardAE, ForwardBE                                   : operand selects
//   StallF/D/E/M, FlushD/E/W                               : pipeline control
//   MemTimeout                                             : sticky watchdog flag
// Stall/flush/forward outputs are combinational so single-cycle memory
// sees zero added latency; only MemTimeout and the counters are flops.
// -----------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WAIT_LIMIT     = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [1:0]                ResultSrcE,
    input  logic                      PCSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic                      MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      StallCnt,
    output logic [CNT_WIDTH-1:0]      FlushCnt,
    output logic [CNT_WIDTH-1:0]      MemWaitCnt
`endif
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);
    localparam bit CFG_OK = (WAIT_LIMIT >= 1) && (WAIT_LIMIT <= 255) && (CNT_WIDTH >= 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("hazard_controller: WAIT_LIMIT must be 1..255 and CNT_WIDTH >= 1");
        end
    endgenerate

    fwd_sel_t   fwd_a_s;
    fwd_sel_t   fwd_b_s;
    logic       freeze_s;
    logic       lw_stall_s;
    hz_state_t  state_q;
    hz_state_t  state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    logic       mem_timeout_q;
    logic       mem_timeout_d;

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a_s)
    );

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b_s)
    );

    assign freeze_s   = MemReqM && !MemReadyM;
    assign lw_stall_s = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != REG_ZERO)
                        && ((RdE == Rs1D) || (RdE == Rs2D));

    // Pipeline control: reset forces bubbles, freeze outranks branch, branch outranks load-use.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
            if (freeze_s) begin
                // Hold every stage; Writeback gets bubbles so nothing retires twice.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // Decode holds a wrong-path instruction, so a pending load-use is moot.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall_s) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else begin
                StallF = 1'b0;
            end
        end
    end

    // Next-state, watchdog count and sticky timeout computation.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = 8'd0;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (freeze_s) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = RUN;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Count only cycles spent waiting; any return to RUN clears it.
        if ((state_q == MEM_WAIT) && (state_d == MEM_WAIT)) begin
            wait_cnt_d = sat_inc8(wait_cnt_q);
        end else begin
            wait_cnt_d = 8'd0;
        end
        if (freeze_s && (wait_cnt_q == LIMIT_M1)) begin
            mem_timeout_d = 1'b1;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end
    end

    // FSM state, watchdog count and sticky timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign MemTimeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d;
    logic [CNT_WIDTH-1:0] wait_stat_q;
    logic [CNT_WIDTH-1:0] wait_stat_d;

    // Event counters track the control actually applied, not the raw requests.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_stat_d = wait_stat_q;
        if (freeze_s) begin
            wait_stat_d = wait_stat_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (PCSrcE) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (lw_stall_s) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            flush_cnt_q <= {CNT_WIDTH{1'b0}};
            wait_stat_q <= {CNT_WIDTH{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_stat_q <= wait_stat_d;
        end
    end

    assign StallCnt   = stall_cnt_q;
    assign FlushCnt   = flush_cnt_q;
    assign MemWaitCnt = wait_stat_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed, table-driven bench for hazard_controller (WAIT_LIMIT = 4).
// Output bundle compared as {ForwardAE, ForwardBE, StallF, StallD, StallE,
// StallM, FlushD, FlushE, FlushW, MemTimeout}. Counter checks are compiled
// in when HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt, MemWaitCnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_controller #(.REG_ADDR_WIDTH(5), .WAIT_LIMIT(4), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .MemTimeout (MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt),
        .MemWaitCnt (MemWaitCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0]  rsrc;
        logic        pc;
        logic [4:0]  rdm, rdw;
        logic        rwm, rww, req, rdy;
        logic [11:0] exp;
    } vec_t;

    localparam logic [11:0] O_IDLE   = 12'b00_00_0000_000_0;
    localparam logic [11:0] O_LWSTL  = 12'b00_00_1100_010_0;
    localparam logic [11:0] O_BRFL   = 12'b00_00_0000_110_0;
    localparam logic [11:0] O_FREEZE = 12'b00_00_1111_001_0;
    localparam logic [11:0] O_RESET  = 12'b00_00_0000_111_0;

    vec_t vecs [15];

    function automatic logic [11:0] outs();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, MemTimeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
        ResultSrcE = v.rsrc; PCSrcE = v.pc; RdM = v.rdm; RdW = v.rdw;
        RegWriteM = v.rwm; RegWriteW = v.rww; MemReqM = v.req; MemReadyM = v.rdy;
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b1;
    endtask

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lw();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    initial begin
        //            rs1d  rs2d  rs1e   rs2e   rde   rsrc   pc    rdm    rdw   rwm   rww   req   rdy   exp
        vecs[0]  = '{5'd0, 5'd0, 5'd5,  5'd0,  5'd0, 2'b00, 1'b0, 5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 12'b10_00_0000_000_0};
        vecs[1]  = '{5'd0, 5'd0, 5'd5,  5'd0,  5'd0, 2'b00, 1'b0, 5'd0,  5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 12'b01_00_0000_000_0};
        vecs[2]  = '{5'd0, 5'd0, 5'd5,  5'd0,  5'd0, 2'b00, 1'b0, 5'd0,  5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE};
        vecs[3]  = '{5'd0, 5'd0, 5'd3,  5'd3,  5'd0, 2'b00, 1'b0, 5'd3,  5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 12'b01_01_0000_000_0};
        vecs[4]  = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 2'b00, 1'b0, 5'd0,  5'd0, 1'b1, 1'b1, 1'b0, 1'b1, O_IDLE};
        vecs[5]  = '{5'd0, 5'd0, 5'd9,  5'd12, 5'd0, 2'b00, 1'b0, 5'd12, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 12'b01_10_0000_000_0};
        vecs[6]  = '{5'd0, 5'd7, 5'd0,  5'd0,  5'd7, 2'b01, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_LWSTL};
        vecs[7]  = '{5'd7, 5'd0, 5'd0,  5'd0,  5'd7, 2'b01, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_LWSTL};
        vecs[8]  = '{5'd7, 5'd0, 5'd0,  5'd0,  5'd7, 2'b00, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE};
        vecs[9]  = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 2'b01, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE};
        vecs[10] = '{5'd7, 5'd0, 5'd0,  5'd0,  5'd7, 2'b01, 1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_BRFL};
        vecs[11] = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 2'b00, 1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_BRFL};
        vecs[12] = '{5'd0, 5'd7, 5'd0,  5'd0,  5'd7, 2'b01, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_LWSTL};
        vecs[13] = '{5'd7, 5'd0, 5'd0,  5'd0,  5'd7, 2'b10, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE};
        vecs[14] = '{5'd4, 5'd0, 5'd4,  5'd0,  5'd4, 2'b01, 1'b0, 5'd4,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b10_00_1100_010_0};

        // Reset state: forwarding suppressed, bubbles everywhere, no timeout.
        idle();
        rst = 1'b1;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'(O_RESET));
        next_cycle();
        rst = 1'b0;
        idle();

        // Combinational table in RUN (no vector stalls on memory).
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            next_cycle();
        end

        // Load-use bubble lasts one cycle once the load moves on.
        idle();
        set_lw();
        @(negedge clk);
        chk("lw_bubble", 32'(outs()), 32'(O_LWSTL));
        next_cycle();
        ResultSrcE = 2'b00;
        @(negedge clk);
        chk("lw_released", 32'(outs()), 32'(O_IDLE));
        next_cycle();

        // Freeze for 3 cycles masks a pending branch and load-use.
        idle();
        set_lw();
        PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("freeze%0d", i), 32'(outs()), 32'(O_FREEZE));
            next_cycle();
        end
        MemReadyM = 1'b1;
        @(negedge clk);
        chk("freeze_release_branch", 32'(outs()), 32'(O_BRFL));
        next_cycle();
        idle();
        @(negedge clk);
        chk("after_freeze_idle", 32'(outs()), 32'(O_IDLE));
        next_cycle();

        // Watchdog: limit 4, six freeze cycles; flag appears in the sixth.
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("wd_wait%0d", i), 32'(outs()),
                32'(O_FREEZE | ((i == 5) ? 12'd1 : 12'd0)));
            next_cycle();
        end
        MemReadyM = 1'b1;
        @(negedge clk);
        chk("wd_sticky_ready", 32'(outs()), 32'(12'd1));
        next_cycle();
        idle();
        @(negedge clk);
        chk("wd_sticky_idle", 32'(outs()), 32'(12'd1));
        rst = 1'b1;
        #2;
        chk("wd_reset_mid", 32'(outs()), 32'(O_RESET));
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("wd_cleared", 32'(outs()), 32'(O_IDLE));
        next_cycle();

`ifdef HAZARD_PERF_CNT_EN
        // 2 load-use stalls, 1 branch flush, 3 freeze cycles.
        set_lw();
        next_cycle();
        next_cycle();
        idle();
        PCSrcE = 1'b1;
        next_cycle();
        idle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        MemReadyM = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        chk("perf_stall_cnt", StallCnt, 32'd2);
        chk("perf_flush_cnt", FlushCnt, 32'd1);
        chk("perf_wait_cnt", MemWaitCnt, 32'd3);
        next_cycle();
        set_lw();
        next_cycle();
        rst = 1'b1;
        #2;
        chk("perf_rst_stall", StallCnt, 32'd0);
        chk("perf_rst_flush", FlushCnt, 32'd0);
        chk("perf_rst_wait", MemWaitCnt, 32'd0);
        next_cycle();
        rst = 1'b0;
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
